// File: rtl/wave_pkg.sv
// Shared definitions for the sine sample path (lookup, mixer and PWM output stage).
package wave_pkg;
   localparam int SAMPLE_W = 10;
   localparam logic [SAMPLE_W-1:0] MIDSCALE = 10'h1FF;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } pwm_state_t;
endpackage

// File: rtl/pwm_dac_out_if.sv
// Sample handshake between the wave generator (master) and the PWM output stage (slave).
interface pwm_dac_out_if
   import wave_pkg::*;
#(
   parameter int WIDTH = SAMPLE_W
) ();
   logic [WIDTH-1:0] sample_in;
   logic             sample_valid;
   logic             sample_ready;

   modport master (output sample_in, output sample_valid, input sample_ready);
   modport slave  (input sample_in, input sample_valid, output sample_ready);
endinterface

// File: rtl/pwm_dac_out_tick_gen.sv
// PWM tick prescaler: one tick every PRESCALE clocks, held at zero phase while clear is high.
module pwm_tick_gen #(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);
   generate
      if (PRESCALE <= 1) begin : g_every
         logic unused_inputs;
         assign unused_inputs = clk ^ rst;
         assign tick = !clear;
      end else begin : g_div
         localparam int CW = $clog2(PRESCALE);
         localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);
         logic [CW-1:0] cnt_q, cnt_d;

         always_comb begin
            cnt_d = cnt_q + CW'(1);
            if (clear || cnt_q == LAST) begin
               cnt_d = '0;
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_d;
            end
         end

         assign tick = !clear && (cnt_q == LAST);
      end
   endgenerate
endmodule

// File: rtl/pwm_dac_out.sv
// PWM DAC output stage: one-entry sample buffer feeding a frame-synchronous duty register.
module pwm_dac_out
   import wave_pkg::*;
#(
   parameter int               WIDTH      = SAMPLE_W,
   parameter int               PRESCALE   = 1,
   parameter logic [WIDTH-1:0] RESET_DUTY = WIDTH'(MIDSCALE)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         enable,
   pwm_dac_out_if.slave smp,
   output logic         pwm_out,
   output logic         frame_start,
   output logic         underrun
);
   localparam logic [WIDTH-1:0] CNT_MAX = '1;

   pwm_state_t       state_q, state_d;
   logic [WIDTH-1:0] counter_q, counter_d;
   logic [WIDTH-1:0] duty_q, duty_d;
   logic [WIDTH-1:0] buf_q, buf_d;
   logic             buf_full_q, buf_full_d;
   logic             pwm_q, pwm_d;
   logic             frame_start_q, frame_start_d;
   logic             underrun_q, underrun_d;
   logic             tick, accept, frame_go;

   pwm_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
      .clk   (clk),
      .rst   (rst),
      .clear (state_q == IDLE),
      .tick  (tick)
   );

   always_comb begin
      state_d    = state_q;
      counter_d  = counter_q;
      duty_d     = duty_q;
      buf_d      = buf_q;
      buf_full_d = buf_full_q;
      frame_go   = 1'b0;
      accept     = smp.sample_valid && !buf_full_q;

      case (state_q)
         IDLE: begin
            counter_d = '0;
            if (enable) begin
               state_d  = RUN;
               frame_go = 1'b1;
            end
         end
         RUN: begin
            if (!enable) begin
               state_d   = IDLE;
               counter_d = '0;
            end else if (tick) begin
               counter_d = counter_q + WIDTH'(1);
               frame_go  = (counter_q == CNT_MAX);
            end
         end
         default: state_d = IDLE;
      endcase

      // Accept and reload are mutually exclusive: accept needs an empty buffer, reload a full one.
      if (accept) begin
         buf_d      = smp.sample_in;
         buf_full_d = 1'b1;
      end
      if (frame_go && buf_full_q) begin
         duty_d     = buf_q;
         buf_full_d = 1'b0;
      end

      underrun_d    = frame_go && !buf_full_q;
      frame_start_d = frame_go;
      pwm_d         = (state_q == RUN) && enable && (counter_q < duty_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         counter_q     <= '0;
         duty_q        <= RESET_DUTY;
         buf_q         <= '0;
         buf_full_q    <= 1'b0;
         pwm_q         <= 1'b0;
         frame_start_q <= 1'b0;
         underrun_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         counter_q     <= counter_d;
         duty_q        <= duty_d;
         buf_q         <= buf_d;
         buf_full_q    <= buf_full_d;
         pwm_q         <= pwm_d;
         frame_start_q <= frame_start_d;
         underrun_q    <= underrun_d;
      end
   end

   assign smp.sample_ready = !buf_full_q;
   assign pwm_out          = pwm_q;
   assign frame_start      = frame_start_q;
   assign underrun         = underrun_q;
endmodule
